// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA arbiter and access sequencer for the single-ported data memory
// DMEM_ARB_CPU_PRIO_EN: fixed CPU priority on ties; round-robin when undefined.
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [DM_ADDRESS-1:0] cpu_addr,
   input  logic [DATA_W-1:0]     cpu_wdata,
   input  logic [2:0]            cpu_funct3,
   output logic                  cpu_gnt,
   output logic                  cpu_rvalid,
   output logic [DATA_W-1:0]     cpu_rdata,
   input  logic                  dma_req,
   input  logic                  dma_we,
   input  logic [DM_ADDRESS-1:0] dma_addr,
   input  logic [DATA_W-1:0]     dma_wdata,
   input  logic [2:0]            dma_funct3,
   output logic                  dma_gnt,
   output logic                  dma_rvalid,
   output logic [DATA_W-1:0]     dma_rdata,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic [DM_ADDRESS-1:0] a,
   output logic [DATA_W-1:0]     wd,
   output logic [2:0]            Funct3,
   input  logic [DATA_W-1:0]     rd,
   output logic                  busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

   state_t                state_q, state_d;
   logic                  sel_dma_q, sel_dma_d;
   logic                  we_q, we_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [DATA_W-1:0]     cpu_rdata_q, dma_rdata_q;
   logic                  pick_dma;
   logic                  in_access, in_resp;

`ifdef DMEM_ARB_CPU_PRIO_EN
   assign pick_dma = ~cpu_req;
`else
   // Pointer starts at DMA so the CPU wins the first tie; it only moves on ties.
   logic last_dma_q, last_dma_d;
   logic tie;
   assign tie        = cpu_req & dma_req;
   assign pick_dma   = tie ? ~last_dma_q : dma_req;
   assign last_dma_d = (state_q == IDLE && tie) ? pick_dma : last_dma_q;

   always_ff @(posedge clk) begin
      if (reset) last_dma_q <= 1'b1;
      else       last_dma_q <= last_dma_d;
   end
`endif

   always_comb begin
      state_d   = state_q;
      sel_dma_d = sel_dma_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      funct3_d  = funct3_q;
      case (state_q)
         IDLE: begin
            if (cpu_req || dma_req) begin
               state_d   = ACCESS;
               sel_dma_d = pick_dma;
               we_d      = pick_dma ? dma_we     : cpu_we;
               addr_d    = pick_dma ? dma_addr   : cpu_addr;
               wdata_d   = pick_dma ? dma_wdata  : cpu_wdata;
               funct3_d  = pick_dma ? dma_funct3 : cpu_funct3;
            end
         end
         ACCESS:  state_d = we_q ? IDLE : RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         sel_dma_q <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         funct3_q  <= '0;
      end else begin
         state_q   <= state_d;
         sel_dma_q <= sel_dma_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         funct3_q  <= funct3_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_rdata_q <= '0;
         dma_rdata_q <= '0;
      end else if (state_q == ACCESS && !we_q) begin
         if (sel_dma_q) dma_rdata_q <= rd;
         else           cpu_rdata_q <= rd;
      end
   end

   // Reset gates every strobe so nothing reaches memory or a requester mid-reset.
   assign in_access  = (state_q == ACCESS) & ~reset;
   assign in_resp    = (state_q == RESP) & ~reset;

   assign MemWrite   = in_access & we_q;
   assign MemRead    = in_access & ~we_q;
   assign a          = in_access ? addr_q   : '0;
   assign wd         = in_access ? wdata_q  : '0;
   assign Funct3     = in_access ? funct3_q : '0;
   assign cpu_gnt    = in_access & ~sel_dma_q;
   assign dma_gnt    = in_access & sel_dma_q;
   assign cpu_rvalid = in_resp & ~sel_dma_q;
   assign dma_rvalid = in_resp & sel_dma_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dma_rdata  = dma_rdata_q;
   assign busy       = (state_q != IDLE) & ~reset;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized self-checking bench for dmem_arbiter with a transaction-level model
module tb_dmem_arbiter;
   localparam int AW = 9;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dma_req, dma_we;
   logic [AW-1:0] cpu_addr, dma_addr;
   logic [DW-1:0] cpu_wdata, dma_wdata;
   logic [2:0]    cpu_funct3, dma_funct3;
   logic          cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
   logic [DW-1:0] cpu_rdata, dma_rdata;
   logic          MemRead, MemWrite, busy;
   logic [AW-1:0] a;
   logic [DW-1:0] wd, rd;
   logic [2:0]    Funct3;

   dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_funct3(dma_funct3), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
      .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3), .rd(rd),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Word-organised memory behind the arbiter.
   logic [DW-1:0] mem [0:127] = '{default: '0};
   assign rd = mem[a[8:2]];
   always @(posedge clk) if (MemWrite) mem[a[8:2]] <= wd;

   // Reference model: memory image, per-port read data, tie pointer, per-port request fields.
   logic [DW-1:0] ref_mem [0:127] = '{default: '0};
   logic [DW-1:0] ref_rdata [2];
   bit            last_dma;
   bit            e_we [2];
   logic [AW-1:0] e_addr [2];
   logic [DW-1:0] e_wd [2];
   logic [2:0]    e_f3 [2];
   int            cnt [2];
   logic [7:0]    order;
   int            ngr;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_port(input int p);
      if (p == 0) begin
         cpu_req = (cnt[0] > 0); cpu_we = e_we[0]; cpu_addr = e_addr[0];
         cpu_wdata = e_wd[0]; cpu_funct3 = e_f3[0];
      end else begin
         dma_req = (cnt[1] > 0); dma_we = e_we[1]; dma_addr = e_addr[1];
         dma_wdata = e_wd[1]; dma_funct3 = e_f3[1];
      end
   endtask

   task automatic model_reset();
      last_dma = 1'b1;
      ref_rdata[0] = '0;
      ref_rdata[1] = '0;
   endtask

   // Called at a negedge with the arbiter idle; serves every pending access per the model.
   task automatic run_round();
      drive_port(0);
      drive_port(1);
      ngr = 0;
      order = '0;
      while (cnt[0] > 0 || cnt[1] > 0) begin
         int w;
         if (cnt[0] > 0 && cnt[1] > 0) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
            w = 0;
`else
            w = last_dma ? 0 : 1;
            last_dma = (w == 1);
`endif
         end else begin
            w = (cnt[0] > 0) ? 0 : 1;
         end
         @(posedge clk);
         #1;
         // Post-sampling field changes must not reach memory.
         if (w == 0) cpu_addr = e_addr[0] + 9'h020;
         else        dma_addr = e_addr[1] + 9'h020;
         @(negedge clk);
         check("gnt", {cpu_gnt, dma_gnt}, (w == 0) ? 2'b10 : 2'b01);
         check("mem_en", {MemWrite, MemRead}, e_we[w] ? 2'b10 : 2'b01);
         check("addr", a, e_addr[w]);
         check("wd", wd, e_wd[w]);
         check("funct3", Funct3, e_f3[w]);
         check("busy_acc", busy, 1'b1);
         order[ngr] = w[0];
         ngr++;
         cnt[w]--;
         drive_port(w);
         if (e_we[w]) begin
            ref_mem[e_addr[w][8:2]] = e_wd[w];
         end else begin
            ref_rdata[w] = ref_mem[e_addr[w][8:2]];
            @(negedge clk);
            check("rvalid", {cpu_rvalid, dma_rvalid}, (w == 0) ? 2'b10 : 2'b01);
            check("resp_mem", {MemWrite, MemRead, a, Funct3}, '0);
         end
         check("cpu_rdata", cpu_rdata, ref_rdata[0]);
         check("dma_rdata", dma_rdata, ref_rdata[1]);
         @(negedge clk);
         check("idle", {busy, cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, MemRead, MemWrite}, '0);
      end
   endtask

   task automatic set_port(input int p, input int n, input bit we, input logic [AW-1:0] ad,
                           input logic [DW-1:0] d, input logic [2:0] f3);
      cnt[p] = n; e_we[p] = we; e_addr[p] = ad; e_wd[p] = d; e_f3[p] = f3;
   endtask

   initial begin
      reset = 1'b1;
      set_port(0, 0, 1'b0, '0, '0, '0);
      set_port(1, 0, 1'b0, '0, '0, '0);
      drive_port(0);
      drive_port(1);
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_outs", {cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, MemRead, MemWrite, busy, a, wd, Funct3}, '0);
      check("rst_rdata", {cpu_rdata, dma_rdata}, '0);
      reset = 1'b0;
      @(negedge clk);

      set_port(0, 1, 1'b1, 9'h010, 32'hDEADBEEF, 3'b010);
      run_round();
      set_port(0, 1, 1'b0, 9'h010, 32'h0, 3'b010);
      run_round();
      check("cpu_load_val", cpu_rdata, 32'hDEADBEEF);

      set_port(0, 2, 1'b0, 9'h010, 32'h0, 3'b010);
      set_port(1, 2, 1'b0, 9'h010, 32'h0, 3'b000);
      run_round();
`ifdef DMEM_ARB_CPU_PRIO_EN
      check("grant_order", order[3:0], 4'b1100);
`else
      check("grant_order", order[3:0], 4'b1010);
`endif

      set_port(1, 1, 1'b1, 9'h1FC, 32'h12345678, 3'b010);
      run_round();
      check("dma_store_mem", mem[127], 32'h12345678);

      set_port(0, 1, 1'b1, 9'h020, 32'hA5A5A5A5, 3'b001);
      run_round();

      // Reset lands in the ACCESS cycle of a DMA store.
      set_port(1, 1, 1'b1, 9'h004, 32'hFFFFFFFF, 3'b010);
      drive_port(1);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_acc_memwrite", MemWrite, 1'b0);
      check("rst_acc_gnt", dma_gnt, 1'b0);
      cnt[1] = 0;
      drive_port(1);
      @(posedge clk);
      @(negedge clk);
      check("rst_acc_busy", busy, 1'b0);
      reset = 1'b0;
      model_reset();
      check("rst_nowrite", mem[1], 32'h0);
      set_port(1, 1, 1'b0, 9'h004, 32'h0, 3'b010);
      run_round();

      // Reset lands in RESP of a CPU load.
      set_port(0, 1, 1'b0, 9'h010, 32'h0, 3'b010);
      drive_port(0);
      @(posedge clk);
      @(negedge clk);
      check("rr_gnt", cpu_gnt, 1'b1);
      cnt[0] = 0;
      drive_port(0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("rst_resp_rvalid", cpu_rvalid, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("rst_resp_busy", busy, 1'b0);
      check("rst_resp_rdata", cpu_rdata, 32'h0);
      reset = 1'b0;
      model_reset();
      @(negedge clk);

      for (int r = 0; r < 40; r++) begin
         for (int p = 0; p < 2; p++)
            set_port(p, $urandom_range(0, 2), 1'($urandom), {7'($urandom_range(0, 127)), 2'b00},
                     $urandom, 3'($urandom_range(0, 7)));
         run_round();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
